pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage miniRV core.
//  - Generates stall/flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
//  - Handles load-use hazards, taken branch/jump redirects and data-memory wait states.
//  - Keeps saturating performance counters for retired instructions, stall cycles and flushes.
//  - Sits beside the pipeline registers; takes ID/EX/WB stage fields and drives their hold/clear.
// PARAMETERS
//  CNT_W        32  width of each performance counter
//  MEM_TIMEOUT  15  MEM_WAIT cycles after which err_timeout sets (range 1..255)
// PORTS
//  clk_i          in   1      core clock, all state on rising edge
//  rst_i          in   1      synchronous reset, active-high
//  id_rs1         in   5      rs1 index of instruction in ID
//  id_rs2         in   5      rs2 index of instruction in ID
//  id_rs1_used    in   1      ID instruction reads rs1
//  id_rs2_used    in   1      ID instruction reads rs2
//  ex_wr          in   5      destination register of instruction in EX
//  ex_rf_we       in   1      EX instruction writes the register file
//  ex_is_load     in   1      EX instruction is a load (write data comes from DRAM)
//  ex_redirect    in   1      EX resolved a taken branch/jump (PC redirected this cycle)
//  mem_busy       in   1      data memory not ready; MEM stage must hold
//  wb_have_inst   in   1      WB stage holds a valid instruction (retires this cycle)
//  pc_stall       out  1      hold PC
//  if_id_stall    out  1      hold IF/ID
//  if_id_flush    out  1      clear IF/ID to bubble (have_inst=0)
//  id_ex_stall    out  1      hold ID/EX
//  id_ex_flush    out  1      clear ID/EX to bubble
//  ex_mem_stall   out  1      hold EX/MEM
//  mem_wb_flush   out  1      clear MEM/WB to bubble
//  err_timeout    out  1      sticky: MEM_WAIT reached MEM_TIMEOUT
//  retired_cnt    out  CNT_W  instructions retired
//  stall_cnt      out  CNT_W  cycles with pc_stall=1
//  flush_cnt      out  CNT_W  redirect flush events
// BEHAVIOUR
//  - Reset: all control outputs 0 while rst_i=1.
//    Next edge sets state=RUN, clears counters, wait counter and err_timeout.
//  - Control outputs are combinational from state and inputs; counters and flags are registered.
//  - Load-use hazard:
//    lu = ex_is_load & ex_rf_we & (ex_wr!=0) & ((id_rs1_used & id_rs1==ex_wr) | (id_rs2_used & id_rs2==ex_wr)).
//  - FSM states: RUN, LU_BUBBLE, MEM_WAIT. Priority within a cycle: mem_busy > ex_redirect > lu.
//  - RUN and LU_BUBBLE, mem_busy=1:
//    pc/if_id/id_ex/ex_mem stall=1, mem_wb_flush=1, flushes 0; next state MEM_WAIT.
//  - RUN and LU_BUBBLE, ex_redirect=1 (mem_busy=0):
//    if_id_flush=1, id_ex_flush=1, no stalls; flush_cnt+1; next state RUN.
//    A redirect overrides and kills a pending load-use stall.
//  - RUN, lu=1 (no busy/redirect):
//    pc_stall=1, if_id_stall=1, id_ex_flush=1; next state LU_BUBBLE.
//  - LU_BUBBLE: lu is ignored (EX now holds a bubble); otherwise identical to RUN.
//    Next state RUN. Exactly one bubble per load-use.
//  - MEM_WAIT, mem_busy=1: same controls as entry; wait counter +1.
//    err_timeout sets when the wait counter reaches MEM_TIMEOUT.
//    It stays set until reset; stalling continues.
//  - MEM_WAIT, mem_busy=0: controls decoded exactly as RUN, including redirect and lu.
//    Wait counter clears. Next state: LU_BUBBLE if lu was taken, else RUN.
//  - ex_redirect while mem_busy=1 is not acted on; EX is frozen, so redirect is honoured on release.
//  - Counters saturate at all-ones; never wrap.
//    retired_cnt+1 when wb_have_inst=1 and mem_wb_flush=0; stall_cnt+1 when pc_stall=1.
//  - Reset asserted mid-stall or mid-MEM_WAIT: outputs drop to 0 immediately; RUN after the edge.
// TESTING
//  - Reset: rst_i=1 for 2 cycles with mem_busy=1 -> all controls 0, counters 0, state RUN after release.
//  - Load-use: ex_is_load=1, ex_rf_we=1, ex_wr=5, id_rs1=5, id_rs1_used=1 ->
//    1 cycle pc_stall=if_id_stall=id_ex_flush=1, then controls 0 with the same inputs held; stall_cnt=1.
//  - x0 load: ex_wr=0 with a rs1 match -> no stall.
//  - Redirect with lu: ex_redirect=1 and lu=1 -> if_id_flush=id_ex_flush=1, pc_stall=0; flush_cnt=1.
//  - Memory wait: mem_busy=1 for 4 cycles -> 4 cycles of all stalls plus mem_wb_flush;
//    wb_have_inst=1 does not retire; stall_cnt=4; release cycle controls 0.
//  - Timeout and saturation: mem_busy held for 20 cycles, MEM_TIMEOUT=15 -> err_timeout=1 from the
//    15th wait cycle and sticky after release; with CNT_W=4, 17 retires -> retired_cnt=4'hF.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller.
// Ports (master = pipeline side, slave = controller):
//   ID/EX/MEM/WB stage fields into the controller;
//   stall/flush controls, sticky timeout flag and performance counters out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_wr;
  logic             ex_rf_we;
  logic             ex_is_load;
  logic             ex_redirect;
  logic             mem_busy;
  logic             wb_have_inst;

  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_stall;
  logic             id_ex_flush;
  logic             ex_mem_stall;
  logic             mem_wb_flush;
  logic             err_timeout;
  logic [CNT_W-1:0] retired_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_wr, ex_rf_we,
           ex_is_load, ex_redirect, mem_busy, wb_have_inst,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_flush, err_timeout, retired_cnt, stall_cnt,
           flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_wr, ex_rf_we,
           ex_is_load, ex_redirect, mem_busy, wb_have_inst,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_flush, err_timeout, retired_cnt, stall_cnt,
           flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage miniRV core.
// Produces hold/clear controls for PC and the four pipeline registers from
// load-use hazards, EX redirects and data-memory wait states, and keeps
// saturating retire/stall/flush counters plus a sticky memory-timeout flag.
// Ports:
//   clk_i  - core clock, rising edge
//   rst_i  - synchronous reset, active-high (controls forced low while high)
//   bus    - pipe_hazard_ctrl_if.slave: stage fields in, controls/counters out
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pipe_hazard_ctrl_if.slave   bus
);

  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_BUBBLE = 2'd1,
    ST_MEM_WAIT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    ret_q, ret_d;
  logic [CNT_W-1:0]    stall_q, stall_d;
  logic [CNT_W-1:0]    flush_q, flush_d;

  logic lu;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, mem_wb_flush, redirect_evt;

  // Load in EX whose destination is read by the instruction in ID
  assign lu = bus.ex_is_load & bus.ex_rf_we & (bus.ex_wr != 5'd0) &
              ((bus.id_rs1_used & (bus.id_rs1 == bus.ex_wr)) |
               (bus.id_rs2_used & (bus.id_rs2 == bus.ex_wr)));

  // Next state and controls; priority mem_busy > ex_redirect > lu
  always_comb begin
    state_d      = state_q;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    redirect_evt = 1'b0;
    if (rst_i) begin
      state_d = ST_RUN;
    end else if (bus.mem_busy) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
      state_d      = ST_MEM_WAIT;
    end else if (bus.ex_redirect) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      redirect_evt = 1'b1;
      state_d      = ST_RUN;
    end else if (lu && (state_q != ST_LU_BUBBLE)) begin
      // EX already holds the bubble in LU_BUBBLE, so lu is not re-taken there
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = ST_LU_BUBBLE;
    end else begin
      state_d = ST_RUN;
    end
  end

  // Wait counter, sticky timeout and saturating performance counters
  always_comb begin
    wait_d  = '0;
    err_d   = err_q;
    ret_d   = ret_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if ((state_q == ST_MEM_WAIT) && bus.mem_busy) begin
      wait_d = (&wait_q) ? wait_q : wait_q + WAIT_W'(1);
      if (wait_d >= WAIT_W'(MEM_TIMEOUT)) err_d = 1'b1;
    end
    if (bus.wb_have_inst && !mem_wb_flush && !(&ret_q)) ret_d = ret_q + CNT_W'(1);
    if (pc_stall && !(&stall_q)) stall_d = stall_q + CNT_W'(1);
    if (redirect_evt && !(&flush_q)) flush_d = flush_q + CNT_W'(1);
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      ret_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc_stall     = pc_stall;
  assign bus.if_id_stall  = if_id_stall;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_stall  = id_ex_stall;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.ex_mem_stall = ex_mem_stall;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.err_timeout  = err_q;
  assign bus.retired_cnt  = ret_q;
  assign bus.stall_cnt    = stall_q;
  assign bus.flush_cnt    = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned TIMEOUT = 15;
  localparam int          CMAX    = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus_if ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: behaviour tracked as plain flags and integer counts
  bit m_bubble;   // previous cycle inserted a load-use bubble
  bit m_waiting;  // previous cycle was a memory stall
  int m_waits;    // stalled cycles spent after the first one
  bit m_err;
  int m_ret, m_stall, m_flush;

  function automatic bit lu_f();
    return bus_if.ex_is_load && bus_if.ex_rf_we && (bus_if.ex_wr != 0) &&
           ((bus_if.id_rs1_used && bus_if.id_rs1 == bus_if.ex_wr) ||
            (bus_if.id_rs2_used && bus_if.id_rs2 == bus_if.ex_wr));
  endfunction

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
  function automatic logic [6:0] exp_ctl();
    if (rst) return 7'b0000000;
    if (bus_if.mem_busy) return 7'b1101011;
    if (bus_if.ex_redirect) return 7'b0010100;
    if (lu_f() && !m_bubble) return 7'b1100100;
    return 7'b0000000;
  endfunction

  function automatic logic [6:0] dut_ctl();
    return {bus_if.pc_stall, bus_if.if_id_stall, bus_if.if_id_flush,
            bus_if.id_ex_stall, bus_if.id_ex_flush, bus_if.ex_mem_stall,
            bus_if.mem_wb_flush};
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Advance one clock and the model alongside it; inputs sampled as currently driven
  task automatic tick();
    logic [6:0] c;
    bit l, rd;
    c  = exp_ctl();
    l  = lu_f();
    rd = bus_if.ex_redirect;
    @(posedge clk);
    if (rst) begin
      m_bubble = 0; m_waiting = 0; m_waits = 0; m_err = 0;
      m_ret = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (bus_if.mem_busy) begin
        if (m_waiting) m_waits++;
        if (m_waits >= TIMEOUT) m_err = 1;
        m_waiting = 1;
        m_bubble  = 0;
      end else begin
        m_waiting = 0;
        m_waits   = 0;
        m_bubble  = !rd && l && !m_bubble;
        if (rd) m_flush = sat(m_flush + 1);
      end
      if (c[6]) m_stall = sat(m_stall + 1);
      if (bus_if.wb_have_inst && !c[0]) m_ret = sat(m_ret + 1);
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.id_rs1 = 0; bus_if.id_rs2 = 0; bus_if.id_rs1_used = 0; bus_if.id_rs2_used = 0;
    bus_if.ex_wr = 0; bus_if.ex_rf_we = 0; bus_if.ex_is_load = 0; bus_if.ex_redirect = 0;
    bus_if.mem_busy = 0; bus_if.wb_have_inst = 0;
  endtask

  task automatic set_lu(input logic [4:0] wr, input logic [4:0] rs1);
    bus_if.ex_is_load = 1; bus_if.ex_rf_we = 1; bus_if.ex_wr = wr;
    bus_if.id_rs1 = rs1; bus_if.id_rs1_used = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus_if.mem_busy = 1;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (dut_ctl() !== 7'b0) begin
        bad++; $display("FAIL reset_ctl cyc=%0d got=%b want=0000000", i, dut_ctl());
      end
      tick();
    end
    rst = 0;
    bus_if.mem_busy = 0;
    total++;
    if ({bus_if.retired_cnt, bus_if.stall_cnt, bus_if.flush_cnt, bus_if.err_timeout} !== 13'b0) begin
      bad++; $display("FAIL reset_cnt got=%h/%h/%h err=%b want=0", bus_if.retired_cnt,
                      bus_if.stall_cnt, bus_if.flush_cnt, bus_if.err_timeout);
    end
    set_lu(5'd7, 5'd7);
    #1;
    total++;
    if (dut_ctl() !== 7'b1100100) begin
      bad++; $display("FAIL reset_run got=%b want=1100100", dut_ctl());
    end
    idle_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu(5'd5, 5'd5);
    #1;
    total++;
    if (dut_ctl() !== 7'b1100100) begin
      bad++; $display("FAIL lu_stall got=%b want=1100100", dut_ctl());
    end
    tick();
    total++;
    if (dut_ctl() !== 7'b0000000) begin
      bad++; $display("FAIL lu_bubble got=%b want=0000000", dut_ctl());
    end
    tick();
    total++;
    if (int'(bus_if.stall_cnt) !== 1) begin
      bad++; $display("FAIL lu_stall_cnt got=%0d want=1", bus_if.stall_cnt);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0_load();
    do_reset();
    set_lu(5'd0, 5'd0);
    #1;
    total++;
    if (dut_ctl() !== 7'b0000000) begin
      bad++; $display("FAIL x0_load got=%b want=0000000", dut_ctl());
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_redirect_lu();
    do_reset();
    set_lu(5'd9, 5'd9);
    bus_if.ex_redirect = 1;
    #1;
    total++;
    if (dut_ctl() !== 7'b0010100) begin
      bad++; $display("FAIL redir_ctl got=%b want=0010100", dut_ctl());
    end
    tick();
    idle_inputs();
    total++;
    if (int'(bus_if.flush_cnt) !== 1 || int'(bus_if.stall_cnt) !== 0) begin
      bad++; $display("FAIL redir_cnt flush=%0d stall=%0d want=1/0", bus_if.flush_cnt, bus_if.stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    bus_if.mem_busy = 1;
    bus_if.wb_have_inst = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (dut_ctl() !== 7'b1101011) begin
        bad++; $display("FAIL memwait_ctl cyc=%0d got=%b want=1101011", i, dut_ctl());
      end
      tick();
    end
    bus_if.mem_busy = 0;
    bus_if.wb_have_inst = 0;
    #1;
    total++;
    if (dut_ctl() !== 7'b0000000) begin
      bad++; $display("FAIL memwait_release got=%b want=0000000", dut_ctl());
    end
    total++;
    if (int'(bus_if.stall_cnt) !== 4 || int'(bus_if.retired_cnt) !== 0) begin
      bad++; $display("FAIL memwait_cnt stall=%0d ret=%0d want=4/0", bus_if.stall_cnt, bus_if.retired_cnt);
    end
    tick();
  endtask

  task automatic test_timeout_sat();
    do_reset();
    bus_if.mem_busy = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (bus_if.err_timeout !== m_err) begin
        bad++; $display("FAIL timeout cyc=%0d got=%b want=%b", i, bus_if.err_timeout, m_err);
      end
    end
    bus_if.mem_busy = 0;
    for (int i = 0; i < 17; i++) begin
      bus_if.wb_have_inst = 1;
      tick();
    end
    bus_if.wb_have_inst = 0;
    total++;
    if (bus_if.err_timeout !== 1'b1) begin
      bad++; $display("FAIL timeout_sticky got=%b want=1", bus_if.err_timeout);
    end
    total++;
    if (bus_if.retired_cnt !== 4'hF || bus_if.stall_cnt !== 4'hF) begin
      bad++; $display("FAIL saturate ret=%h stall=%h want=F/F", bus_if.retired_cnt, bus_if.stall_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus_if.id_rs1 = 5'($urandom_range(0, 3));
      bus_if.id_rs2 = 5'($urandom_range(0, 3));
      bus_if.id_rs1_used = 1'($urandom_range(0, 1));
      bus_if.id_rs2_used = 1'($urandom_range(0, 1));
      bus_if.ex_wr = 5'($urandom_range(0, 3));
      bus_if.ex_rf_we = ($urandom_range(0, 3) != 0);
      bus_if.ex_is_load = ($urandom_range(0, 1) != 0);
      bus_if.ex_redirect = ($urandom_range(0, 5) == 0);
      bus_if.mem_busy = ($urandom_range(0, 4) == 0);
      bus_if.wb_have_inst = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 60) == 0);
      #1;
      total++;
      if (dut_ctl() !== exp_ctl()) begin
        bad++; $display("FAIL rand_ctl cyc=%0d got=%b want=%b", i, dut_ctl(), exp_ctl());
      end
      tick();
      total++;
      if (int'(bus_if.retired_cnt) !== m_ret || int'(bus_if.stall_cnt) !== m_stall ||
          int'(bus_if.flush_cnt) !== m_flush || bus_if.err_timeout !== m_err) begin
        bad++; $display("FAIL rand_cnt cyc=%0d got=%0d/%0d/%0d/%b want=%0d/%0d/%0d/%b", i,
                        bus_if.retired_cnt, bus_if.stall_cnt, bus_if.flush_cnt, bus_if.err_timeout,
                        m_ret, m_stall, m_flush, m_err);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_x0_load();
    test_redirect_lu();
    test_mem_wait();
    test_timeout_sat();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
